axi4_mem_slave: RTL and testbench

- Parametrised AXI4 memory slave; successor to the fixed 32-bit axi_slave.
- Adds ID, WSTRB, 2-bit responses, FIXED/INCR/WRAP bursts, narrow transfers and SLVERR on illegal or out-of-range accesses.
- Write and read paths are independent and run concurrently against one internal register array.
- Sits behind axi_master inside axi4_top, replacing axi_slave.

---
 rtl/axi4_pkg.sv | 19 +
 rtl/axi4_burst_addr_gen.sv | 30 +++
 rtl/axi4_mem_slave.sv | 155 +++++++++++++++
 tb/tb_axi4_mem_slave.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 burst/response encodings, FSM states and burst legality check
package axi4_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  // Only the low address byte matters: alignment never exceeds 128 bytes.
  function automatic logic burst_legal(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input logic [7:0] addr_lo,
                                       input logic [2:0] max_size);
    logic wrap_ok;
    wrap_ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
              ((addr_lo & ((8'd1 << size) - 8'd1)) == 8'd0);
    return size <= max_size && burst != 2'b11 && (burst != BURST_WRAP || wrap_ok);
  endfunction
endpackage

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: next beat address plus word index and range check for one address
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               len,
  input  logic [2:0]               size,
  input  logic [1:0]               burst,
  output logic [ADDR_W-1:0]        next_addr,
  output logic [$clog2(DEPTH)-1:0] word,
  output logic                     in_range
);
  localparam int LB = $clog2(DATA_W/8);
  logic [ADDR_W-1:0] incr, cont, step, off;
  assign incr = ADDR_W'(1) << size;
  assign cont = ADDR_W'({1'b0, len} + 9'd1) << size;
  assign step = (addr & ~(incr - ADDR_W'(1))) + incr;
  // WRAP keeps the container base and lets the aligned step roll over inside it
  assign next_addr = burst == BURST_FIXED ? addr :
                     burst == BURST_WRAP  ? (addr & ~(cont - ADDR_W'(1))) | (step & (cont - ADDR_W'(1))) :
                     step;
  assign off = addr - BASE_ADDR;
  assign word = off[LB +: $clog2(DEPTH)];
  assign in_range = addr >= BASE_ADDR && (off >> LB) < ADDR_W'(DEPTH);
endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 memory slave with independent write/read burst FSMs over one array
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));
  logic [DATA_W-1:0] mem [DEPTH];
  wstate_t ws, ws_nx;
  rstate_t rs, rs_nx;
  logic [ADDR_W-1:0] w_addr, w_next, r_addr, r_next;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [2:0] w_size, r_size;
  logic [1:0] w_burst, r_burst;
  logic [AW-1:0] w_word, r_word;
  logic w_err, w_legal, r_legal, w_inr, r_inr, aw_lg, r_lg, r_ok, r_idle;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign b_hs = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs = rvalid && rready;
  assign wready = ws == W_DATA;
  assign bvalid = ws == W_RESP;
  assign bresp = bvalid && w_err ? RESP_SLVERR : RESP_OKAY;
  assign rvalid = rs == R_DATA;
  assign r_idle = rs == R_IDLE;
  assign aw_lg = burst_legal(awlen, awsize, awburst, awaddr[7:0], MAX_SIZE);
  assign r_lg = r_idle ? burst_legal(arlen, arsize, arburst, araddr[7:0], MAX_SIZE) : r_legal;
  assign r_ok = r_lg && r_inr;
  always_comb begin
    ws_nx = ws == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
            ws == W_DATA ? (w_hs && w_cnt == w_len ? W_RESP : W_DATA) :
            (b_hs ? W_IDLE : W_RESP);
    rs_nx = r_idle ? (ar_hs ? R_DATA : R_IDLE) : (r_hs && rlast ? R_IDLE : R_DATA);
  end
  axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wgen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
    .next_addr(w_next), .word(w_word), .in_range(w_inr)
  );
  // The read generator looks at the AR request while idle, then at the prefetch pointer
  axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rgen (
    .addr(r_idle ? araddr : r_addr), .len(r_idle ? arlen : r_len),
    .size(r_idle ? arsize : r_size), .burst(r_idle ? arburst : r_burst),
    .next_addr(r_next), .word(r_word), .in_range(r_inr)
  );
  always_ff @(posedge clk)
    if (w_hs && w_legal && w_inr)
      for (int b = 0; b < DATA_W/8; b++)
        if (wstrb[b]) mem[w_word][8*b +: 8] <= wdata[8*b +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ws <= W_IDLE;
      awready <= 1'b0;
      bid <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
      w_legal <= 1'b0;
    end else begin
      ws <= ws_nx;
      awready <= ws_nx == W_IDLE;
      if (aw_hs) begin
        bid <= awid;
        w_addr <= awaddr;
        w_len <= awlen;
        w_size <= awsize;
        w_burst <= awburst;
        w_cnt <= '0;
        w_legal <= aw_lg;
        w_err <= !aw_lg;
      end
      if (w_hs) begin
        w_addr <= w_next;
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err || !w_inr || (wlast != (w_cnt == w_len));
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rs <= R_IDLE;
      arready <= 1'b0;
      rid <= '0;
      rdata <= '0;
      rresp <= '0;
      rlast <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      r_legal <= 1'b0;
    end else begin
      rs <= rs_nx;
      arready <= rs_nx == R_IDLE;
      if (ar_hs) begin
        rid <= arid;
        r_len <= arlen;
        r_size <= arsize;
        r_burst <= arburst;
        r_legal <= r_lg;
        r_cnt <= '0;
        rlast <= arlen == 8'd0;
      end
      if (ar_hs || (r_hs && !rlast)) begin
        rdata <= r_ok ? mem[r_word] : '0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
        r_addr <= r_next;
      end
      if (r_hs && !rlast) begin
        r_cnt <= r_cnt + 8'd1;
        rlast <= r_cnt + 8'd1 == r_len;
      end
    end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: directed self-checking bench for axi4_mem_slave (DEPTH=16)
module tb_axi4_mem_slave;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] awid, arid, bid, rid, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  int errors = 0, checks = 0;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0] rr [16];
  logic rl [16];
  logic [3:0] got_id, b_id;
  logic [1:0] b_resp;

  axi4_mem_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH(16), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n;
    n = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) begin checks++; errors++; $display("FAIL aw_timeout awready=%0b required 1", awready); end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] len, input logic [3:0] strb, input int last_at);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      wdata = wd[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) begin checks++; errors++; $display("FAIL w_timeout beat=%0d wready=%0b required 1", i, wready); end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b();
    int n;
    n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL b_timeout bvalid=%0b required 1", bvalid); end
    b_id = bid; b_resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] strb, input int last_at);
    send_aw(id, a, len, sz, bu);
    send_w(len, strb, last_at);
    get_b();
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n;
    n = 0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin checks++; errors++; $display("FAIL ar_timeout arready=%0b required 1", arready); end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n;
    send_ar(id, a, len, sz, bu);
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      if (!rvalid) begin checks++; errors++; $display("FAIL r_timeout beat=%0d rvalid=%0b required 1", i, rvalid); end
      rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; got_id = rid;
      tick();
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata} !== 50'd0)
      begin errors++; $display("FAIL reset_outputs got=%h required 0",
        {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({awready, arready} !== 2'b00) begin errors++; $display("FAIL ready_before_edge got=%b required 00", {awready, arready}); end
    tick();
    checks++;
    if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL ready_after_release got=%b required 11", {awready, arready}); end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    do_write(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 3);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%b required 00", b_resp); end
    checks++;
    if (b_id !== 4'd5) begin errors++; $display("FAIL incr_bid got=%h required 5", b_id); end
    do_read(4'd9, 32'h10, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd[i], rr[i], rl[i]} !== {32'(i + 1), 2'b00, i == 3})
        begin errors++; $display("FAIL incr_read beat=%0d got data=%h resp=%b last=%b required data=%h resp=00 last=%b",
          i, rd[i], rr[i], rl[i], i + 1, i == 3); end
    end
    checks++;
    if (got_id !== 4'd9) begin errors++; $display("FAIL incr_rid got=%h required 9", got_id); end
  endtask

  task automatic test_wrap();
    logic [31:0] e [4];
    e = '{32'd3, 32'd4, 32'd1, 32'd2};
    do_read(4'd2, 32'h18, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd[i], rr[i], rl[i]} !== {e[i], 2'b00, i == 3})
        begin errors++; $display("FAIL wrap_read beat=%0d got data=%h resp=%b last=%b required data=%h resp=00 last=%b",
          i, rd[i], rr[i], rl[i], e[i], i == 3); end
    end
    do_read(4'd3, 32'h18, 8'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd[i], rr[i], rl[i]} !== {32'd0, 2'b10, i == 2})
        begin errors++; $display("FAIL wrap_len2 beat=%0d got data=%h resp=%b last=%b required data=0 resp=10 last=%b",
          i, rd[i], rr[i], rl[i], i == 2); end
    end
  endtask

  task automatic test_strobe();
    wd[0] = 32'h11223344;
    do_write(4'd1, 32'h28, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    wd[0] = 32'hAABBCCDD;
    do_write(4'd1, 32'h28, 8'd0, 3'd2, 2'b01, 4'b0011, 0);
    do_read(4'd1, 32'h28, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rd[0] !== 32'h1122CCDD) begin errors++; $display("FAIL strobe_merge got=%h required 1122ccdd", rd[0]); end
    wd[0] = 32'h11; wd[1] = 32'h55;
    do_write(4'd1, 32'h20, 8'd1, 3'd2, 2'b01, 4'hF, 1);
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
    do_write(4'd1, 32'h20, 8'd2, 3'd2, 2'b00, 4'hF, 2);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got=%b required 00", b_resp); end
    do_read(4'd1, 32'h20, 8'd1, 3'd2, 2'b01);
    checks++;
    if ({rd[0], rd[1]} !== {32'hA2, 32'h55}) begin errors++; $display("FAIL fixed_read got=%h %h required a2 55", rd[0], rd[1]); end
  endtask

  task automatic test_range();
    logic [31:0] e [4];
    logic [1:0] er [4];
    e = '{32'hE0, 32'hE1, 32'h0, 32'h0};
    er = '{2'b00, 2'b00, 2'b10, 2'b10};
    wd[0] = 32'h12345678;
    do_write(4'd1, 32'h00, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    for (int i = 0; i < 4; i++) wd[i] = 32'hE0 + 32'(i);
    do_write(4'd6, 32'h38, 8'd3, 3'd2, 2'b01, 4'hF, 3);
    checks++;
    if ({b_id, b_resp} !== {4'd6, 2'b10}) begin errors++; $display("FAIL range_bresp got id=%h resp=%b required id=6 resp=10", b_id, b_resp); end
    do_read(4'd6, 32'h38, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd[i], rr[i]} !== {e[i], er[i]})
        begin errors++; $display("FAIL range_read beat=%0d got data=%h resp=%b required data=%h resp=%b", i, rd[i], rr[i], e[i], er[i]); end
    end
    do_read(4'd6, 32'h00, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rd[0] !== 32'h12345678) begin errors++; $display("FAIL range_no_alias got=%h required 12345678", rd[0]); end
  endtask

  task automatic test_illegal();
    wd[0] = 32'h77;
    do_write(4'd1, 32'h30, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    wd[0] = 32'hFF;
    do_write(4'd1, 32'h30, 8'd0, 3'd2, 2'b11, 4'hF, 0);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL illegal_burst_bresp got=%b required 10", b_resp); end
    do_write(4'd1, 32'h30, 8'd0, 3'd3, 2'b01, 4'hF, 0);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL illegal_size_bresp got=%b required 10", b_resp); end
    do_read(4'd1, 32'h30, 8'd0, 3'd2, 2'b01);
    checks++;
    if ({rd[0], rr[0]} !== {32'h77, 2'b00}) begin errors++; $display("FAIL illegal_no_write got=%h resp=%b required 77 resp=00", rd[0], rr[0]); end
    do_read(4'd1, 32'h30, 8'd1, 3'd3, 2'b01);
    checks++;
    if ({rd[0], rr[0], rl[0], rd[1], rr[1], rl[1]} !== {32'h0, 2'b10, 1'b0, 32'h0, 2'b10, 1'b1})
      begin errors++; $display("FAIL illegal_read got %h/%b/%b %h/%b/%b required 0/10/0 0/10/1",
        rd[0], rr[0], rl[0], rd[1], rr[1], rl[1]); end
  endtask

  task automatic test_wlast();
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
    do_write(4'd7, 32'h00, 8'd3, 3'd2, 2'b01, 4'hF, 1);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL wlast_early_bresp got=%b required 10", b_resp); end
    do_read(4'd7, 32'h00, 8'd3, 3'd2, 2'b01);
    checks++;
    if ({rd[0], rd[1], rd[2], rd[3]} !== {32'hC0, 32'hC1, 32'hC2, 32'hC3})
      begin errors++; $display("FAIL wlast_data got=%h %h %h %h required c0 c1 c2 c3", rd[0], rd[1], rd[2], rd[3]); end
    do_write(4'd7, 32'h00, 8'd1, 3'd2, 2'b01, 4'hF, -1);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL wlast_missing_bresp got=%b required 10", b_resp); end
    do_write(4'd7, 32'h08, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL err_cleared_bresp got=%b required 00", b_resp); end
  endtask

  task automatic test_back_to_back();
    logic stable;
    send_ar(4'd4, 32'h10, 8'd3, 3'd2, 2'b01);
    rready = 1'b1;
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'd1}) begin errors++; $display("FAIL stall_beat0 got valid=%b data=%h required 1 1", rvalid, rdata); end
    tick();
    rready = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if ({rvalid, rlast, rdata} !== {1'b1, 1'b0, 32'd2}) stable = 1'b0;
      if (k < 2) tick();
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL r_stall_stable got=%b required 1 (data=%h)", stable, rdata); end
    rready = 1'b1;
    tick();
    checks++;
    if ({rlast, rdata} !== {1'b0, 32'd3}) begin errors++; $display("FAIL stall_beat2 got last=%b data=%h required 0 3", rlast, rdata); end
    tick();
    checks++;
    if ({rlast, rdata} !== {1'b1, 32'd4}) begin errors++; $display("FAIL stall_beat3 got last=%b data=%h required 1 4", rlast, rdata); end
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL stall_end rvalid=%b required 0", rvalid); end
    wd[0] = 32'd1;
    send_aw(4'hA, 32'h10, 8'd0, 3'd2, 2'b01);
    send_w(8'd0, 4'hF, 0);
    bready = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if ({bvalid, bid, bresp} !== {1'b1, 4'hA, 2'b00}) stable = 1'b0;
      if (k < 5) tick();
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL b_stall_stable got=%b required 1 (bvalid=%b bid=%h)", stable, bvalid, bid); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if ({bvalid, awready} !== 2'b01) begin errors++; $display("FAIL b_done got bvalid/awready=%b required 01", {bvalid, awready}); end
  endtask

  task automatic test_reset_mid();
    send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
    rready = 1'b1;
    tick(); tick();
    rready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rvalid, rlast, arready, awready} !== 4'b0000)
      begin errors++; $display("FAIL async_reset got rvalid/rlast/arready/awready=%b required 0000", {rvalid, rlast, arready, awready}); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b0) begin errors++; $display("FAIL arready_at_release got=%b required 0", arready); end
    tick();
    checks++;
    if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL arready_after_release got=%b required 10", {arready, rvalid}); end
    do_read(4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
    checks++;
    if ({rd[0], rd[1], rd[2], rd[3]} !== {32'd1, 32'd2, 32'd3, 32'd4})
      begin errors++; $display("FAIL mem_preserved got=%h %h %h %h required 1 2 3 4", rd[0], rd[1], rd[2], rd[3]); end
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_range();
    test_illegal();
    test_wlast();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
